// File: rtl/cic_interp_feeder_if.sv
// Valid/ready sample stream into the CIC interpolator feeder.
// master = upstream sample source, slave = feeder.
interface cic_interp_feeder_if #(
  parameter int ISZ = 16
);
  logic                  valid;
  logic                  ready;
  logic signed [ISZ-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/cic_interp_feeder.sv
// Buffers baseband samples and hands one to the CIC interpolator every RATIO out_clk
// cycles as a one-cycle strobe plus a held word; flags and counts underruns.
module cic_interp_feeder #(
  parameter int ISZ   = 16,
  parameter int RATIO = 256,
  parameter int DEPTH = 4
) (
  input  logic                   out_clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   zero_on_underrun,
  cic_interp_feeder_if.slave     s,
  output logic                   strobe,
  output logic signed [ISZ-1:0]  sample,
  output logic                   underrun,
  output logic [15:0]            underrun_count,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(RATIO - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic signed [ISZ-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [PW-1:0]         phase;
  logic                  push;
  logic                  fire;
  logic                  empty;
  logic                  pop;

  assign s.ready = !reset && (level < FULL_LEVEL);
  assign push    = s.valid && s.ready;
  assign fire    = enable && (phase == LAST_PHASE);
  assign empty   = (level == '0);
  assign pop     = fire && !empty;

  // Storage needs no reset: occupancy is tracked entirely by the pointers and level.
  always_ff @(posedge out_clk) begin
    if (push) mem[wptr] <= s.data;
  end

  always_ff @(posedge out_clk) begin
    if (reset) begin
      phase          <= '0;
      wptr           <= '0;
      rptr           <= '0;
      level          <= '0;
      strobe         <= 1'b0;
      underrun       <= 1'b0;
      sample         <= '0;
      underrun_count <= '0;
    end else begin
      phase    <= (!enable || fire) ? '0 : phase + 1'b1;
      strobe   <= fire;
      underrun <= fire && empty;
      if (push) wptr <= wptr + 1'b1;
      // Empty strobe either repeats the last word or forces silence.
      if (pop) begin
        rptr   <= rptr + 1'b1;
        sample <= mem[rptr];
      end else if (fire && zero_on_underrun) begin
        sample <= '0;
      end
      underrun_count <= (fire && empty) ? sat_inc16(underrun_count) : underrun_count;
      level          <= level + LW'(push) - LW'(pop);
    end
  end
endmodule

// File: tb/tb_cic_interp_feeder.sv
// Bench for cic_interp_feeder (RATIO=8, DEPTH=4): directed steps plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_cic_interp_feeder;
  localparam int ISZ   = 16;
  localparam int RATIO = 8;
  localparam int DEPTH = 4;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic                  zou;
  logic                  strobe;
  logic signed [ISZ-1:0] sample;
  logic                  underrun;
  logic [15:0]           underrun_count;
  logic [2:0]            level;

  cic_interp_feeder_if #(.ISZ(ISZ)) sif ();

  cic_interp_feeder #(.ISZ(ISZ), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
    .out_clk          (clk),
    .reset            (rst),
    .enable           (en),
    .zero_on_underrun (zou),
    .s                (sif),
    .strobe           (strobe),
    .sample           (sample),
    .underrun         (underrun),
    .underrun_count   (underrun_count),
    .level            (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic signed [ISZ-1:0] q[$];
  int                    run = 0;
  logic signed [ISZ-1:0] last = '0;
  int                    cnt = 0;
  bit                    stb_e = 0;
  bit                    und_e = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One out_clk cycle: model predicts from pre-edge state, DUT is checked after the edge.
  task automatic cycle();
    bit rdy;
    bit push;
    bit fire;
    #1;
    rdy = !rst && (q.size() < DEPTH);
    chk("s_ready", sif.ready, rdy);
    push = sif.valid && rdy;
    if (rst) begin
      q.delete();
      run = 0; last = '0; cnt = 0; stb_e = 0; und_e = 0;
    end else begin
      fire  = en && ((run % RATIO) == RATIO - 1);
      stb_e = fire;
      und_e = 0;
      if (fire) begin
        if (q.size() > 0) last = q.pop_front();
        else begin
          und_e = 1;
          if (zou) last = '0;
          if (cnt < 65535) cnt++;
        end
      end
      if (push) q.push_back(sif.data);
      run = en ? run + 1 : 0;
    end
    @(posedge clk);
    #1;
    chk("strobe", strobe, stb_e);
    chk("sample", sample, last);
    chk("underrun", underrun, und_e);
    chk("underrun_count", underrun_count, cnt);
    chk("level", level, q.size());
  endtask

  task automatic idle(input int n);
    sif.valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    int guard = 0;
    sif.valid = 1'b0;
    while (q.size() > 0 && guard < 8 * RATIO) begin cycle(); guard++; end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic push_one(input logic signed [ISZ-1:0] v);
    int guard = 0;
    bit done = 0;
    sif.data  = v;
    sif.valid = 1'b1;
    while (!done && guard < 4 * RATIO) begin
      done = !rst && (q.size() < DEPTH);
      cycle();
      guard++;
    end
    sif.valid = 1'b0;
    chk("push_timeout", done, 1);
  endtask

  task automatic wait_strobe(output logic signed [ISZ-1:0] s, output logic u);
    int guard = 0;
    s = 'x; u = 1'bx;
    sif.valid = 1'b0;
    while (guard < 2 * RATIO) begin
      cycle();
      guard++;
      if (strobe === 1'b1) begin s = sample; u = underrun; break; end
    end
    chk("strobe_timeout", (guard < 2 * RATIO) || (strobe === 1'b1), 1);
  endtask

  task automatic wait_phase(input int ph);
    int guard = 0;
    while ((run % RATIO) != ph && guard < 2 * RATIO) begin cycle(); guard++; end
    chk("phase_timeout", run % RATIO, ph);
  endtask

  initial begin
    logic signed [ISZ-1:0] got[$];
    logic signed [ISZ-1:0] s1;
    logic signed [ISZ-1:0] sv;
    logic                  u1;
    int                    guard;

    rst = 1'b1; en = 1'b0; zou = 1'b0;
    sif.valid = 1'b0; sif.data = '0;

    // Reset, then idle with enable and no data: underrun strobes at 8, 16, 24
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("reset_ready", sif.ready, 0);
    end
    chk("reset_level", level, 0);
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      cycle();
      chk("idle_strobe", strobe, (i % 8) == 0);
      if ((i % 8) == 0) begin
        chk("idle_underrun", underrun, 1);
        chk("idle_sample", sample, 0);
        chk("idle_count", underrun_count, i / 8);
      end
    end

    // Steady stream 1..6 back-to-back
    sif.valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      sif.data = ISZ'(k);
      guard = 0;
      while (guard < 4 * RATIO) begin
        guard++;
        if (!rst && q.size() < DEPTH) begin
          cycle();
          if (k == 4) begin
            chk("full_level", level, 4);
            #1 chk("full_ready", sif.ready, 0);
          end
          break;
        end
        cycle();
        if (strobe === 1'b1) got.push_back(sample);
      end
      if (strobe === 1'b1 && got.size() < k) got.push_back(sample);
    end
    sif.valid = 1'b0;
    guard = 0;
    while (got.size() < 6 && guard < 8 * RATIO) begin
      cycle(); guard++;
      if (strobe === 1'b1) begin
        got.push_back(sample);
        chk("stream_no_underrun", underrun, 0);
      end
    end
    chk("stream_count", got.size(), 6);
    for (int k = 0; k < 6 && k < got.size(); k++) chk("stream_order", got[k], k + 1);

    // Hold-last and zero-on-underrun
    drain();
    wait_phase(0);
    push_one(16'sh7FFF);
    wait_strobe(s1, u1);
    chk("hold_first", s1, 16'h7FFF);
    chk("hold_first_u", u1, 0);
    wait_strobe(s1, u1);
    chk("hold_second", s1, 16'h7FFF);
    chk("hold_second_u", u1, 1);
    zou = 1'b1;
    push_one(16'sh1234);
    wait_strobe(s1, u1);
    chk("zero_first", s1, 16'h1234);
    wait_strobe(s1, u1);
    chk("zero_second", s1, 0);
    chk("zero_second_u", u1, 1);
    zou = 1'b0;

    // Push into empty FIFO on the strobe edge itself
    wait_phase(RATIO - 1);
    sif.valid = 1'b1; sif.data = 16'sh0ABC;
    cycle();
    sif.valid = 1'b0;
    chk("edge_push_underrun", underrun, 1);
    chk("edge_push_level", level, 1);
    wait_strobe(s1, u1);
    chk("edge_push_next", s1, 16'h0ABC);
    chk("edge_push_next_u", u1, 0);

    // Full FIFO at the strobe edge: ready returns one cycle later
    for (int k = 0; k < 4; k++) push_one(ISZ'(16'h100 + k));
    wait_phase(RATIO - 1);
    sif.valid = 1'b1; sif.data = 16'sh0200;
    cycle();
    chk("full_strobe", strobe, 1);
    #1 chk("full_ready_back", sif.ready, 1);
    cycle();
    sif.valid = 1'b0;
    drain();

    // Enable dropped at phase 5 with two samples buffered
    wait_phase(0);
    push_one(16'sh0011);
    push_one(16'sh0022);
    wait_phase(5);
    chk("toggle_level", q.size(), 2);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("toggle_no_strobe", strobe, 0);
    end
    chk("toggle_hold_level", level, 2);
    en = 1'b1;
    for (int i = 1; i <= RATIO; i++) begin
      cycle();
      chk("toggle_strobe", strobe, i == RATIO);
    end
    chk("toggle_sample", sample, 16'h0011);
    chk("toggle_after_level", level, 1);
    drain();

    // Random traffic, bursty then sparse
    for (int i = 0; i < 700; i++) begin
      sif.valid = (i < 350) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
      sv = ISZ'($urandom);
      sif.data = sv;
      en  = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 63) == 0) zou = ~zou;
      cycle();
    end
    sif.valid = 1'b0; en = 1'b1; zou = 1'b0;
    drain();

    // Counter saturation, starting just below the ceiling
    en = 1'b0;
    cycle();
    force dut.underrun_count = 16'hFFFD;
    cnt = 16'hFFFD;
    cycle();
    release dut.underrun_count;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_strobe(s1, u1);
      chk("sat_underrun", u1, 1);
      chk("sat_count", underrun_count, (k == 0) ? 16'hFFFE : 16'hFFFF);
    end

    // Mid-run reset clears count, level and sample
    push_one(16'sh0555);
    push_one(16'sh0666);
    rst = 1'b1;
    cycle();
    chk("mid_reset_count", underrun_count, 0);
    chk("mid_reset_level", level, 0);
    chk("mid_reset_sample", sample, 0);
    rst = 1'b0;
    idle(2 * RATIO);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
